speed_window_checker: RTL and testbench

Parametrised successor to the single-threshold speed checker in the treadmill/pulse datapath. Runs a measurement window of `WINDOW_SEC` one-second ticks and counts the seconds in which `ppm` is in range. The range is either a single threshold or a low/high band, selected at runtime. It reports a saturating hit count, the longest consecutive in-range streak, and a registered pass/fail verdict, and supports pause and rearm.

---
 rtl/speed_window_checker.sv | 137 +++++++++++++
 tb/tb_speed_window_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/speed_window_checker.sv
// speed_window_checker
// Counts in-range seconds over a window of WINDOW_SEC one-second ticks.
// The range is either a threshold (mode 0) or a low/high band (mode 1).
// Reports a saturating hit count, the longest in-range streak, the number of
// samples taken, and a pass verdict registered on entry to DONE.
// Pausing (start low) holds every counter, including the running streak.
module speed_window_checker #(
    parameter int PPM_W      = 10,
    parameter int CNT_W      = 16,
    parameter int TIME_W     = 5,
    parameter int WINDOW_SEC = 10,
    parameter int HIT_SAT    = 9,
    parameter int PASS_MIN   = 9
) (
    input  logic              secondClk,
    input  logic              reset,
    input  logic              start,
    input  logic              rearm,
    input  logic              mode,
    input  logic [PPM_W-1:0]  ppm,
    input  logic [PPM_W-1:0]  lowPpm,
    input  logic [PPM_W-1:0]  highPpm,
    output logic [CNT_W-1:0]  hitCount,
    output logic [CNT_W-1:0]  maxStreak,
    output logic [TIME_W-1:0] elapsed,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [CNT_W-1:0]   curStreak;
    logic               inRange;
    logic               sample;
    logic               lastSample;
    logic [TIME_W-1:0]  elapsedNext;
    logic [CNT_W-1:0]   hitNext;
    logic [CNT_W-1:0]   streakNext;
    logic [CNT_W-1:0]   maxNext;

    // Increment that sticks at HIT_SAT once reached.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        if (value < CNT_W'(HIT_SAT)) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

    // Range test and next-sample values; a band with highPpm < lowPpm never matches.
    always_comb begin
        if (mode) begin
            inRange = (ppm >= lowPpm) && (ppm <= highPpm);
        end else begin
            inRange = (ppm >= lowPpm);
        end
        sample      = start && !rearm && (state != DONE);
        elapsedNext = elapsed + TIME_W'(1);
        lastSample  = (elapsedNext == TIME_W'(WINDOW_SEC));
        hitNext     = inRange ? satInc(hitCount) : hitCount;
        streakNext  = inRange ? curStreak + CNT_W'(1) : '0;
        maxNext     = (streakNext > maxStreak) ? streakNext : maxStreak;
    end

    // Next-state logic; rearm overrides everything except reset.
    always_comb begin
        stateNext = state;
        if (rearm) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (start) begin
                        stateNext = lastSample ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (start) begin
                        stateNext = lastSample ? DONE : RUN;
                    end else begin
                        stateNext = HOLD;
                    end
                end
                DONE: stateNext = DONE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge secondClk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Window counters: cleared by reset/rearm, advanced only on a sample.
    always_ff @(posedge secondClk) begin
        if (reset || rearm) begin
            hitCount  <= '0;
            maxStreak <= '0;
            curStreak <= '0;
            elapsed   <= '0;
        end else if (sample) begin
            hitCount  <= hitNext;
            maxStreak <= maxNext;
            curStreak <= streakNext;
            elapsed   <= elapsedNext;
        end
    end

    // Verdict captured on the edge entering DONE, held there, zero elsewhere.
    always_ff @(posedge secondClk) begin
        if (reset || rearm) begin
            pass <= 1'b0;
        end else if (stateNext == DONE) begin
            if (state != DONE) begin
                pass <= (hitNext >= CNT_W'(PASS_MIN));
            end
        end else begin
            pass <= 1'b0;
        end
    end

    assign busy = (state == RUN) || (state == HOLD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_speed_window_checker.sv
// Bench for speed_window_checker: directed scenarios plus random traffic,
// compared each edge against a window model built from a list of samples.
module tb_speed_window_checker;

    localparam int PPM_W      = 10;
    localparam int CNT_W      = 16;
    localparam int TIME_W     = 5;
    localparam int WINDOW_SEC = 10;
    localparam int HIT_SAT    = 9;
    localparam int PASS_MIN   = 9;

    logic              secondClk = 1'b0;
    logic              reset     = 1'b1;
    logic              start     = 1'b0;
    logic              rearm     = 1'b0;
    logic              mode      = 1'b0;
    logic [PPM_W-1:0]  ppm       = '0;
    logic [PPM_W-1:0]  lowPpm    = '0;
    logic [PPM_W-1:0]  highPpm   = '0;
    logic [CNT_W-1:0]  hitCount;
    logic [CNT_W-1:0]  maxStreak;
    logic [TIME_W-1:0] elapsed;
    logic              busy;
    logic              done;
    logic              pass;

    int compared   = 0;
    int mismatched = 0;

    // Model: the in-range flags of every sample taken in the current window.
    bit mSamples[$];
    bit mDone = 1'b0;

    speed_window_checker #(
        .PPM_W(PPM_W), .CNT_W(CNT_W), .TIME_W(TIME_W),
        .WINDOW_SEC(WINDOW_SEC), .HIT_SAT(HIT_SAT), .PASS_MIN(PASS_MIN)
    ) dut (
        .secondClk(secondClk),
        .reset(reset),
        .start(start),
        .rearm(rearm),
        .mode(mode),
        .ppm(ppm),
        .lowPpm(lowPpm),
        .highPpm(highPpm),
        .hitCount(hitCount),
        .maxStreak(maxStreak),
        .elapsed(elapsed),
        .busy(busy),
        .done(done),
        .pass(pass)
    );

    always #5 secondClk = ~secondClk;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic bit modelInRange(input bit md, input int p, input int lo, input int hi);
        if (md) return (p >= lo) && (p <= hi);
        return p >= lo;
    endfunction

    function automatic int modelHits();
        int n = 0;
        foreach (mSamples[i]) n += mSamples[i];
        return (n > HIT_SAT) ? HIT_SAT : n;
    endfunction

    function automatic int modelLongestRun();
        int best = 0;
        int run = 0;
        foreach (mSamples[i]) begin
            run = mSamples[i] ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    task automatic checkAll();
        int hits;
        hits = modelHits();
        checkVal("hitCount",  32'(hitCount),  32'(hits));
        checkVal("maxStreak", 32'(maxStreak), 32'(modelLongestRun()));
        checkVal("elapsed",   32'(elapsed),   32'(mSamples.size()));
        checkVal("busy",      32'(busy),      32'(mSamples.size() > 0 && !mDone));
        checkVal("done",      32'(done),      32'(mDone));
        checkVal("pass",      32'(pass),      32'(mDone && hits >= PASS_MIN));
    endtask

    // Apply one edge worth of inputs, advance the model, check after the edge.
    task automatic tick(input bit rs, input bit ra, input bit st, input bit md,
                        input int p, input int lo, input int hi);
        reset   = rs;
        rearm   = ra;
        start   = st;
        mode    = md;
        ppm     = PPM_W'(p);
        lowPpm  = PPM_W'(lo);
        highPpm = PPM_W'(hi);
        @(posedge secondClk);
        if (rs || ra) begin
            mSamples.delete();
            mDone = 1'b0;
        end else if (!mDone && st) begin
            mSamples.push_back(modelInRange(md, p, lo, hi));
            if (mSamples.size() == WINDOW_SEC) mDone = 1'b1;
        end
        #1;
        checkAll();
    endtask

    int pat2[10] = '{40, 40, 20, 40, 40, 40, 20, 40, 40, 40};

    initial begin
        // Reset state
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 40, 33, 0);
        checkVal("reset_done", 32'(done), 0);

        // Threshold, all in range: saturated hits, full streak, pass
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 0, 40, 33, 0);
        checkVal("t1_hit", 32'(hitCount), 9);
        checkVal("t1_streak", 32'(maxStreak), 10);
        checkVal("t1_pass", 32'(pass), 1);
        // Samples ignored in DONE
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 10, 33, 0);
        checkVal("t1_hold_elapsed", 32'(elapsed), 10);

        // Rearm in DONE
        tick(0, 1, 0, 0, 0, 33, 0);
        checkVal("rearm_done", 32'(done), 0);

        // Threshold with dropouts
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 0, pat2[i], 33, 0);
        checkVal("t2_hit", 32'(hitCount), 8);
        checkVal("t2_streak", 32'(maxStreak), 3);
        checkVal("t2_pass", 32'(pass), 0);
        checkVal("t2_done", 32'(done), 1);

        // Band, alternating in/out
        tick(0, 1, 0, 1, 0, 30, 50);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, (i % 2 == 0) ? 45 : 60, 30, 50);
        checkVal("t3_hit", 32'(hitCount), 5);
        checkVal("t3_streak", 32'(maxStreak), 1);

        // Inverted band never matches
        tick(0, 1, 0, 1, 0, 50, 30);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 1, 40, 50, 30);
        checkVal("t3b_hit", 32'(hitCount), 0);

        // Pause keeps the streak
        tick(0, 1, 0, 0, 0, 33, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 40, 33, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 10, 33, 0);
            checkVal("t4_pause_elapsed", 32'(elapsed), 4);
            checkVal("t4_pause_busy", 32'(busy), 1);
        end
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, 40, 33, 0);
        checkVal("t4_streak", 32'(maxStreak), 10);
        checkVal("t4_done", 32'(done), 1);

        // Reset mid-window
        tick(0, 1, 0, 0, 0, 33, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 40, 33, 0);
        tick(1, 0, 1, 0, 40, 33, 0);
        checkVal("t5_reset_elapsed", 32'(elapsed), 0);
        checkVal("t5_reset_busy", 32'(busy), 0);

        // Rearm and start together: no sample that edge
        tick(0, 0, 1, 0, 40, 33, 0);
        tick(0, 1, 1, 0, 40, 33, 0);
        checkVal("t6_rearm_start_elapsed", 32'(elapsed), 0);
        tick(0, 0, 1, 0, 40, 33, 0);
        checkVal("t6_first_sample", 32'(elapsed), 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bit rs;
            bit ra;
            bit st;
            bit md;
            rs = ($urandom_range(0, 99) == 0);
            ra = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 3) != 0);
            md = $urandom_range(0, 1);
            tick(rs, ra, st, md, $urandom_range(0, 100),
                 $urandom_range(20, 80), $urandom_range(20, 80));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
